// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/inc/dcr/logic ops plus a WIDTH-cycle
// shift-add multiplier, with a registered result, flags and a tri-state bus drive.
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] accumulator,
  input  logic [WIDTH-1:0] b_register,
  input  logic [2:0]       operation,
  input  logic             start,
  input  logic             alu_out,
  output logic [WIDTH-1:0] bus_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DCR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

  state_e               state_q,  state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q,  flags_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [2*WIDTH-1:0]   prod_q,   prod_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q,    cnt_d;

  logic [WIDTH-1:0]     opb_s;
  logic                 sub_s;
  logic [WIDTH:0]       arith_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_c_s;
  logic                 alu_v_s;
  logic [2*WIDTH-1:0]   prod_next_s;
  logic                 mul_hi_s;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    return {(res == ZERO), c, res[WIDTH-1], v};
  endfunction

  // Single-cycle datapath; MUL (or disabled MUL) falls to the zero default
  always_comb begin
    opb_s     = b_register;
    sub_s     = 1'b0;
    alu_res_s = ZERO;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (operation)
      OP_SUB:  begin opb_s = b_register; sub_s = 1'b1; end
      OP_INC:  begin opb_s = ONE;        sub_s = 1'b0; end
      OP_DCR:  begin opb_s = ONE;        sub_s = 1'b1; end
      default: begin opb_s = b_register; sub_s = 1'b0; end
    endcase
    if (sub_s) begin
      arith_s = {1'b0, accumulator} - {1'b0, opb_s};
    end else begin
      arith_s = {1'b0, accumulator} + {1'b0, opb_s};
    end
    case (operation)
      OP_ADD, OP_SUB, OP_INC, OP_DCR: begin
        alu_res_s = arith_s[WIDTH-1:0];
        alu_c_s   = arith_s[WIDTH];
        // operands agree in sign (add) or differ (sub) and the result sign flips
        alu_v_s   = (accumulator[WIDTH-1] ^ opb_s[WIDTH-1] ^ ~sub_s) &
                    (arith_s[WIDTH-1] ^ accumulator[WIDTH-1]);
      end
      OP_AND:  alu_res_s = accumulator & b_register;
      OP_OR:   alu_res_s = accumulator | b_register;
      OP_XOR:  alu_res_s = accumulator ^ b_register;
      default: alu_res_s = ZERO;
    endcase
  end

  // One shift-add step of the multiplier
  always_comb begin
    prod_next_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    mul_hi_s    = |prod_next_s[2*WIDTH-1:WIDTH];
  end

  // Next-state, commit and handshake logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && (operation == OP_MUL) && MUL_EN) begin
          state_d  = S_MUL;
          busy_d   = 1'b1;
          mcand_d  = {ZERO, accumulator};
          mplier_d = b_register;
          prod_d   = {ZERO, ZERO};
          cnt_d    = CNT_ZERO;
        end else if (start) begin
          result_d = alu_res_s;
          flags_d  = pack_flags(alu_res_s, alu_c_s, alu_v_s);
          done_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        prod_d   = prod_next_s;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = prod_next_s[WIDTH-1:0];
          flags_d  = pack_flags(prod_next_s[WIDTH-1:0], mul_hi_s, mul_hi_s);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over any start or multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= ZERO;
      flags_q  <= 4'b1000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= {ZERO, ZERO};
      prod_q   <= {ZERO, ZERO};
      mplier_q <= ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_out = alu_out ? result_q : {WIDTH{1'bz}};
  assign flags   = flags_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: three instances (8-bit, 16-bit, 8-bit without MUL)
// driven one at a time; a monitor checks every done pulse against a reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic [2:0]  op_in;
  logic [2:0]  start_v;
  logic        alu_out;

  wire [15:0] bus_w   [3];
  wire [3:0]  flags_w [3];
  wire [2:0]  busy_w, done_w;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          g;
    int          cyc;
    logic [15:0] res;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 1) ? 16 : 8;
    localparam bit ME = (g == 2) ? 1'b0 : 1'b1;
    wire [W-1:0] bus_l;
    seq_alu #(.WIDTH(W), .MUL_EN(ME)) u_dut (
      .clk(clk), .rst(rst),
      .accumulator(a_in[W-1:0]), .b_register(b_in[W-1:0]),
      .operation(op_in), .start(start_v[g]), .alu_out(alu_out),
      .bus_out(bus_l), .flags(flags_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
    assign bus_w[g] = 16'(bus_l);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int g);
    return (g == 1) ? 16 : 8;
  endfunction

  function automatic bit is_long_mul(input int g, input logic [2:0] op);
    return (op == 3'd7) && (g != 2);
  endfunction

  // Reference model: plain integer arithmetic on the masked operands
  function automatic exp_t model(input int g, input int ecyc, input logic [2:0] op,
                                 input logic [15:0] ar, input logic [15:0] br);
    exp_t   e;
    int     w;
    longint mask, half, a, b, full, sa, sbv, sr, res;
    bit     c, v;
    w    = width_of(g);
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a    = longint'(ar) & mask;
    b    = longint'(br) & mask;
    if (op == 3'd2 || op == 3'd3) b = 1;
    sa   = (a >= half) ? a - 2 * half : a;
    sbv  = (b >= half) ? b - 2 * half : b;
    c = 1'b0; v = 1'b0; full = 0; sr = 0;
    case (op)
      3'd0, 3'd2: begin full = a + b; c = (full > mask); sr = sa + sbv; v = (sr < -half) || (sr >= half); end
      3'd1, 3'd3: begin full = a - b; c = (a < b);       sr = sa - sbv; v = (sr < -half) || (sr >= half); end
      3'd4: full = a & b;
      3'd5: full = a | b;
      3'd6: full = a ^ b;
      default: begin
        if (g != 2) begin full = a * b; c = (full > mask); v = c; end
        else full = 0;
      end
    endcase
    res     = full & mask;
    e.g     = g;
    e.cyc   = ecyc;
    e.res   = 16'(res);
    e.flags = {(res == 0), c, (res >= half), v};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; drives one start cycle and returns at the next negedge
  task automatic issue(input int g, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int lat;
    a_in = a; b_in = b; op_in = op; start_v[g] = 1'b1;
    lat = 1 + (is_long_mul(g, op) ? width_of(g) : 0);
    sb.push_back(model(g, cyc + lat, op, a, b));
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic run(input int g, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    issue(g, op, a, b);
    if (is_long_mul(g, op)) repeat (width_of(g)) @(negedge clk);
  endtask

  // MUL with busy tracking; stray starts and operand changes while busy must be ignored
  task automatic mul_busy(input int g, input logic [15:0] a, input logic [15:0] b);
    issue(g, 3'd7, a, b);
    chk("busy_first", busy_w[g], 1);
    for (int j = 1; j < width_of(g); j++) begin
      @(negedge clk);
      start_v[g] = (j == 2 || j == 5);
      op_in = 3'd0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      chk("busy_mid", busy_w[g], 1);
    end
    @(negedge clk);
    start_v[g] = 1'b0;
    chk("busy_at_done", busy_w[g], 0);
    chk("done_with_busy_low", done_w[g], 1);
  endtask

  task automatic random_ops(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      run(g, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (done_w[g] === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(g), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("done_instance", 32'(g), 32'(e.g));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("flags", 32'(flags_w[g]), 32'(e.flags));
            chk("result", 32'(bus_w[g]), 32'(e.res));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start_v = 3'b000; alu_out = 1'b1;
    a_in = 16'h0000; b_in = 16'h0000; op_in = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("rst_flags", 32'(flags_w[g]), 32'h8);
      chk("rst_busy", busy_w[g], 0);
      chk("rst_done", done_w[g], 0);
      chk("rst_result", 32'(bus_w[g]), 32'h0);
    end

    // 8-bit instance
    run(0, 3'd0, 16'h00FF, 16'h0001);
    run(0, 3'd1, 16'h0003, 16'h0005);
    run(0, 3'd0, 16'h007F, 16'h0001);
    alu_out = 1'b0;
    #1;
    chk("bus_released", (bus_w[0] !== 16'h0080), 1);
    chk("flags_hold", 32'(flags_w[0]), 32'h3);
    @(negedge clk);
    alu_out = 1'b1;
    mul_busy(0, 16'h0010, 16'h0020);
    mul_busy(0, 16'h000C, 16'h000A);
    run(0, 3'd2, 16'h0041, 16'h0000);
    run(0, 3'd6, 16'h00AA, 16'h00AA);
    run(0, 3'd3, 16'h0080, 16'h0000);
    random_ops(0, 40);

    // reset in the middle of a multiply: no commit, no done
    a_in = 16'h00FF; b_in = 16'h00FF; op_in = 3'd7; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b1; op_in = 3'd0;
    @(negedge clk);
    rst = 1'b0; start_v[0] = 1'b0;
    chk("abort_busy", busy_w[0], 0);
    chk("abort_flags", 32'(flags_w[0]), 32'h8);
    chk("abort_result", 32'(bus_w[0]), 32'h0);
    chk("abort_done", done_w[0], 0);
    repeat (12) @(negedge clk);

    // 16-bit instance
    run(1, 3'd0, 16'hFFFF, 16'h0001);
    run(1, 3'd1, 16'h0003, 16'h0005);
    run(1, 3'd0, 16'h7FFF, 16'h0001);
    mul_busy(1, 16'h0010, 16'h0020);
    mul_busy(1, 16'hFFFF, 16'hFFFF);
    random_ops(1, 30);

    // 8-bit instance without multiplier
    run(2, 3'd0, 16'h00FF, 16'h0001);
    run(2, 3'd7, 16'h000C, 16'h000A);
    run(2, 3'd7, 16'h0010, 16'h0020);
    random_ops(2, 30);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
